// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues paired fetches to a synchronous mem, buffers
// (inst, pc) entries in a circular FIFO and presents up to two per cycle to decode.
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic [63:0] io_mem_instAddr,
  input  logic [31:0] io_mem_inst_0,
  input  logic [31:0] io_mem_inst_1,
  input  logic        io_redirect_valid,
  input  logic [63:0] io_redirect_pc,
  input  logic        io_id_ready,
  output logic        io_id_valid_0,
  output logic        io_id_valid_1,
  output logic [31:0] io_id_inst_0,
  output logic [31:0] io_id_inst_1,
  output logic [63:0] io_id_pc_0,
  output logic [63:0] io_id_pc_1
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1) + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } fetch_entry_t;

  fetch_entry_t   fifo_q [DEPTH];
  logic [63:0]    pc_q, pc_req_q;
  logic           inflight_q;
  logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q, count_next;
  logic [1:0]     pop_n;
  logic           issue;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

  always_comb begin
    pop_n = 2'd0;
    if (!io_redirect_valid && io_id_ready)
      pop_n = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
    count_next = count_q - CW'(pop_n) + (inflight_q ? CW'(2) : CW'(0));
    issue      = !io_redirect_valid && ((count_next + CW'(2)) <= CW'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      pc_req_q   <= RESET_PC;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (io_redirect_valid) begin
      // Dropping inflight discards the pair mem returns next cycle.
      pc_q       <= io_redirect_pc & ~64'd3;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q]             <= '{inst: io_mem_inst_0, pc: pc_req_q};
        fifo_q[ptr_add(wr_ptr_q, 1)] <= '{inst: io_mem_inst_1, pc: pc_req_q + 64'd4};
        wr_ptr_q                     <= ptr_add(wr_ptr_q, 2);
      end
      rd_ptr_q   <= ptr_add(rd_ptr_q, int'(pop_n));
      count_q    <= count_next;
      inflight_q <= issue;
      if (issue) begin
        pc_req_q <= pc_q;
        pc_q     <= pc_q + 64'd8;
      end
    end
  end

  assert property (@(posedge clock) disable iff (reset) count_next <= CW'(DEPTH));

  assign io_mem_instAddr = pc_q;

  logic [1:0]       slot_vld;
  logic [1:0][31:0] slot_inst;
  logic [1:0][63:0] slot_pc;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    fetch_entry_t ent;
    assign ent          = fifo_q[ptr_add(rd_ptr_q, s)];
    assign slot_vld[s]  = !io_redirect_valid && (count_q > CW'(s));
    assign slot_inst[s] = ent.inst;
    assign slot_pc[s]   = ent.pc;
  end

  assign io_id_valid_0 = slot_vld[0];
  assign io_id_valid_1 = slot_vld[1];
  assign io_id_inst_0  = slot_inst[0];
  assign io_id_inst_1  = slot_inst[1];
  assign io_id_pc_0    = slot_pc[0];
  assign io_id_pc_1    = slot_pc[1];
endmodule
